// File: rtl/sliding_window_gen_if.sv
// ---------------------------------------------------------------------------
// sliding_window_gen_if
//   Bundles the pixel-in stream and the 3x3 window-out stream of
//   sliding_window_gen.
//
//   Handshake rule (both streams): a transfer happens on a rising clk edge
//   where valid && ready are both 1. The producer holds valid and data
//   stable until that edge. The consumer may drive ready in any cycle.
//   in_ready is combinational from out_ready, so a stalled window
//   back-pressures the pixel stream within the same cycle.
//
//   Signals
//     in_pixel    [DW]  raster-order pixel
//     in_valid          in_pixel valid
//     in_sof            in_pixel is (row 0, col 0) of a new frame
//     in_ready          block accepts in_pixel this cycle
//     out_valid         sw_pixel_1..9 hold a valid window
//     out_ready         consumer takes the window this cycle
//     sw_pixel_1..9     row-major 3x3 window, 1 = top-left, 9 = bottom-right
//     frame_done        one-cycle pulse after the last window is consumed
//
//   Modports
//     master : the window generator (drives in_ready and the window side)
//     slave  : the environment (drives pixels and out_ready)
// ---------------------------------------------------------------------------
interface sliding_window_gen_if #(
  parameter int DW = 8
);
  logic [DW-1:0] in_pixel;
  logic          in_valid;
  logic          in_sof;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sw_pixel_1;
  logic [DW-1:0] sw_pixel_2;
  logic [DW-1:0] sw_pixel_3;
  logic [DW-1:0] sw_pixel_4;
  logic [DW-1:0] sw_pixel_5;
  logic [DW-1:0] sw_pixel_6;
  logic [DW-1:0] sw_pixel_7;
  logic [DW-1:0] sw_pixel_8;
  logic [DW-1:0] sw_pixel_9;
  logic          frame_done;

  modport master (
    input  in_pixel, in_valid, in_sof, out_ready,
    output in_ready, out_valid, frame_done,
    output sw_pixel_1, sw_pixel_2, sw_pixel_3,
    output sw_pixel_4, sw_pixel_5, sw_pixel_6,
    output sw_pixel_7, sw_pixel_8, sw_pixel_9
  );

  modport slave (
    output in_pixel, in_valid, in_sof, out_ready,
    input  in_ready, out_valid, frame_done,
    input  sw_pixel_1, sw_pixel_2, sw_pixel_3,
    input  sw_pixel_4, sw_pixel_5, sw_pixel_6,
    input  sw_pixel_7, sw_pixel_8, sw_pixel_9
  );
endinterface

// File: rtl/sliding_window_gen.sv
// ---------------------------------------------------------------------------
// sliding_window_gen
//   Streaming 3x3 window generator. Takes a raster-order pixel stream, keeps
//   the two previous image rows in line buffers and emits one 3x3
//   neighbourhood per interior pixel.
//
//   Ports
//     clk          system clock, rising edge
//     rst          asynchronous active-high reset
//     sw_if        sliding_window_gen_if.master (pixel in / window out)
//     dbg_state_o  output-stage state (0 = EMPTY, 1 = FULL)
//
//   Window layout: sw_pixel_1 = (r-2, c-2), sw_pixel_5 = (r-1, c-1),
//   sw_pixel_9 = (r, c), where (r, c) is the pixel whose accept emitted it.
// ---------------------------------------------------------------------------
module sliding_window_gen #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sliding_window_gen_if.master sw_if,
  output logic                 dbg_state_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  out_state_e    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          last_q, last_d;        // held window is the frame's last one
  logic          frame_done_q, frame_done_d;
  logic [DW-1:0] win_q [9];             // index 0..8 = sw_pixel_1..9

  // Line buffers: lb1 holds row r-1, lb0 holds row r-2. Not reset.
  logic [DW-1:0] lb0_q [IMG_W];
  logic [DW-1:0] lb1_q [IMG_W];

  // -------------------------------------------------------------------------
  // Input side
  // -------------------------------------------------------------------------
  logic          in_ready_w;
  logic          accept;
  logic          consume;
  logic          emit;
  logic          at_last;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic [DW-1:0] lb0_rd;
  logic [DW-1:0] lb1_rd;

  assign in_ready_w = (state_q == ST_EMPTY) || sw_if.out_ready;
  assign accept     = sw_if.in_valid && in_ready_w;
  assign consume    = (state_q == ST_FULL) && sw_if.out_ready;

  // in_sof forces the current pixel to (0,0) whatever the counters say.
  assign cur_col = sw_if.in_sof ? '0 : col_q;
  assign cur_row = sw_if.in_sof ? '0 : row_q;

  assign emit    = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign at_last = (cur_row == LAST_ROW) && (cur_col == LAST_COL);

  // Reads use the pre-write contents (read-before-write at the same address).
  assign lb0_rd = lb0_q[cur_col];
  assign lb1_rd = lb1_q[cur_col];

  // -------------------------------------------------------------------------
  // Row/column counters
  // -------------------------------------------------------------------------
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = (cur_row == LAST_ROW) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output-stage FSM: EMPTY (no window) / FULL (window presented)
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (emit) begin
          state_d = ST_FULL;
          last_d  = at_last;
        end
      end
      ST_FULL: begin
        if (sw_if.out_ready) begin
          frame_done_d = last_q;
          // An emitting accept in the consume cycle refills without a bubble.
          if (emit) begin
            last_d = at_last;
          end else begin
            state_d = ST_EMPTY;
            last_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
      col_q        <= col_d;
      row_q        <= row_d;
    end
  end

  // -------------------------------------------------------------------------
  // Window shift register: shift left one column per accept, new right
  // column = {row r-2, row r-1, row r} at the current column. The shift also
  // runs for col < 2 so the window is primed when the interior starts.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else if (accept) begin
      win_q[0] <= win_q[1];
      win_q[1] <= win_q[2];
      win_q[2] <= lb0_rd;
      win_q[3] <= win_q[4];
      win_q[4] <= win_q[5];
      win_q[5] <= lb1_rd;
      win_q[6] <= win_q[7];
      win_q[7] <= win_q[8];
      win_q[8] <= sw_if.in_pixel;
    end
  end

  // -------------------------------------------------------------------------
  // Line buffers: row r-1 ages into row r-2, the new pixel becomes row r-1.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[cur_col] <= lb1_rd;
      lb1_q[cur_col] <= sw_if.in_pixel;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign sw_if.in_ready   = in_ready_w;
  assign sw_if.out_valid  = (state_q == ST_FULL);
  assign sw_if.frame_done = frame_done_q;
  assign sw_if.sw_pixel_1 = win_q[0];
  assign sw_if.sw_pixel_2 = win_q[1];
  assign sw_if.sw_pixel_3 = win_q[2];
  assign sw_if.sw_pixel_4 = win_q[3];
  assign sw_if.sw_pixel_5 = win_q[4];
  assign sw_if.sw_pixel_6 = win_q[5];
  assign sw_if.sw_pixel_7 = win_q[6];
  assign sw_if.sw_pixel_8 = win_q[7];
  assign sw_if.sw_pixel_9 = win_q[8];
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_sliding_window_gen.sv
// ---------------------------------------------------------------------------
// tb_sliding_window_gen
//   Directed bench for sliding_window_gen on a 4x4 image. Inputs change on
//   the falling edge; outputs are sampled one time unit before the rising
//   edge. Each scenario task builds its expected windows from the pixel
//   numbering and compares them against what the monitor collected.
// ---------------------------------------------------------------------------
module tb_sliding_window_gen;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int DW   = 8;
  localparam int HALF = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #HALF clk = ~clk;

  sliding_window_gen_if #(.DW(DW)) sw_if ();
  logic dbg_state;

  sliding_window_gen #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_if       (sw_if),
    .dbg_state_o (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [9*DW-1:0] exp_q[$];
  logic [9*DW-1:0] got_q[$];
  int              win_cyc_q[$];
  int              acc_cyc[16];
  int              fd_cnt, fd_cyc;
  int              stall_cycles, stall_rdy_hi, stall_changed;
  logic [9*DW-1:0] prev_win;
  bit              prev_stall;
  bit              arm_stall = 0;
  bit              hold_low  = 0;
  int              stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- out_ready driver ----------------
  initial begin
    sw_if.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (arm_stall && sw_if.out_valid === 1'b1) begin
        stall_cnt = 5;
        arm_stall = 0;
      end
      sw_if.out_ready = !(hold_low || stall_cnt > 0);
      if (stall_cnt > 0) stall_cnt--;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [9*DW-1:0] w;
    forever begin
      @(negedge clk);
      #(HALF - 1);
      if (!rst) begin
        w = {sw_if.sw_pixel_1, sw_if.sw_pixel_2, sw_if.sw_pixel_3,
             sw_if.sw_pixel_4, sw_if.sw_pixel_5, sw_if.sw_pixel_6,
             sw_if.sw_pixel_7, sw_if.sw_pixel_8, sw_if.sw_pixel_9};
        if (sw_if.out_valid === 1'b1 && sw_if.out_ready === 1'b1) begin
          got_q.push_back(w);
          win_cyc_q.push_back(cyc);
        end
        if (sw_if.frame_done === 1'b1) begin
          fd_cnt++;
          fd_cyc = cyc;
        end
        if (sw_if.out_valid === 1'b1 && sw_if.out_ready === 1'b0) begin
          stall_cycles++;
          if (sw_if.in_ready !== 1'b0) stall_rdy_hi++;
          if (prev_stall && w !== prev_win) stall_changed++;
          prev_stall = 1;
          prev_win   = w;
        end else begin
          prev_stall = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at a falling edge after the accept.
  task automatic send_pixel(input logic [DW-1:0] p, input logic sof, output int acc);
    bit took   = 0;
    int waited = 0;
    acc = -1;
    sw_if.in_pixel = p;
    sw_if.in_valid = 1'b1;
    sw_if.in_sof   = sof;
    while (!took && waited < 60) begin
      #(HALF - 1);
      if (sw_if.in_ready === 1'b1) begin
        took = 1;
        acc  = cyc;
      end
      @(negedge clk);
      waited++;
    end
    sw_if.in_valid = 1'b0;
    sw_if.in_sof   = 1'b0;
    if (!took) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout pixel=%0d: in_ready never 1, required within 60 cycles", p);
    end
  endtask

  task automatic send_frame(input int base, input int first, input int count, input int gap);
    for (int i = first; i < first + count; i++) begin
      send_pixel(DW'(base + i), (i == 0), acc_cyc[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  // Expected windows of a 4x4 frame whose pixel (r,c) = base + 4r + c.
  task automatic push_exp_frame(input int base);
    logic [9*DW-1:0] w;
    logic [DW-1:0]   px;
    for (int r = 1; r <= 2; r++) begin
      for (int c = 1; c <= 2; c++) begin
        w = '0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            px = DW'(base + (r - 1 + i) * W + (c - 1 + j));
            w  = {w[8*DW-1:0], px};
          end
        end
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic clear_mon();
    exp_q.delete();
    got_q.delete();
    win_cyc_q.delete();
    fd_cnt        = 0;
    fd_cyc        = -1;
    stall_cycles  = 0;
    stall_rdy_hi  = 0;
    stall_changed = 0;
    prev_stall    = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    tests_run++;
    if (sw_if.out_valid !== 1'b0 || sw_if.frame_done !== 1'b0 || sw_if.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ctrl got valid=%b done=%b rdy=%b, required 0 0 1",
               sw_if.out_valid, sw_if.frame_done, sw_if.in_ready);
    end
    tests_run++;
    if ({sw_if.sw_pixel_1, sw_if.sw_pixel_5, sw_if.sw_pixel_9} !== '0 || dbg_state !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_window got p1=%0d p5=%0d p9=%0d st=%b, required zeros",
               sw_if.sw_pixel_1, sw_if.sw_pixel_5, sw_if.sw_pixel_9, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_stream();
    int emit_idx[4] = '{10, 11, 14, 15};
    clear_mon();
    push_exp_frame(0);
    send_frame(0, 0, 16, 0);
    repeat (6) @(negedge clk);
    tests_run++;
    if (got_q.size() != 4) begin
      tests_failed++;
      $display("FAIL basic_count got %0d windows, required 4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      tests_run++;
      if (got_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL basic_win%0d got %h, required %h", k, got_q[k], exp_q[k]);
      end
      tests_run++;
      if (win_cyc_q[k] != acc_cyc[emit_idx[k]] + 1) begin
        tests_failed++;
        $display("FAIL basic_latency%0d got cycle %0d, required %0d", k, win_cyc_q[k], acc_cyc[emit_idx[k]] + 1);
      end
    end
    tests_run++;
    if (fd_cnt != 1 || (got_q.size() == 4 && fd_cyc != win_cyc_q[3] + 1)) begin
      tests_failed++;
      $display("FAIL basic_frame_done got count=%0d cycle=%0d, required 1 pulse right after window 4", fd_cnt, fd_cyc);
    end
  endtask

  task automatic test_stall();
    clear_mon();
    push_exp_frame(0);
    arm_stall = 1;
    send_frame(0, 0, 16, 0);
    repeat (12) @(negedge clk);
    tests_run++;
    if (stall_cycles != 5 || stall_rdy_hi != 0 || stall_changed != 0) begin
      tests_failed++;
      $display("FAIL stall_hold got stall=%0d rdy_hi=%0d changed=%0d, required 5 0 0",
               stall_cycles, stall_rdy_hi, stall_changed);
    end
    tests_run++;
    if (got_q.size() != 4) begin
      tests_failed++;
      $display("FAIL stall_count got %0d windows, required 4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      tests_run++;
      if (got_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL stall_win%0d got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    tests_run++;
    if (fd_cnt != 1) begin
      tests_failed++;
      $display("FAIL stall_frame_done got %0d pulses, required 1", fd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    push_exp_frame(0);
    push_exp_frame(100);
    send_frame(0, 0, 16, 0);
    send_frame(100, 0, 16, 0);
    repeat (6) @(negedge clk);
    tests_run++;
    if (got_q.size() != 8) begin
      tests_failed++;
      $display("FAIL b2b_count got %0d windows, required 8", got_q.size());
    end
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      tests_run++;
      if (got_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL b2b_win%0d got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    tests_run++;
    if (fd_cnt != 2) begin
      tests_failed++;
      $display("FAIL b2b_frame_done got %0d pulses, required 2", fd_cnt);
    end
  endtask

  task automatic test_sof_resync();
    clear_mon();
    push_exp_frame(200);
    send_frame(0, 0, 7, 0);       // aborted partial frame
    send_frame(200, 0, 16, 0);    // pixel 200 carries in_sof
    repeat (6) @(negedge clk);
    tests_run++;
    if (got_q.size() != 4) begin
      tests_failed++;
      $display("FAIL sof_count got %0d windows, required 4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      tests_run++;
      if (got_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL sof_win%0d got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    tests_run++;
    if (fd_cnt != 1) begin
      tests_failed++;
      $display("FAIL sof_frame_done got %0d pulses, required 1", fd_cnt);
    end
  endtask

  task automatic test_async_reset();
    clear_mon();
    hold_low = 1;
    @(negedge clk);
    send_frame(0, 0, 11, 0);
    tests_run++;
    if (sw_if.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_precond got out_valid=%b, required 1", sw_if.out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (sw_if.out_valid !== 1'b0 || sw_if.frame_done !== 1'b0 || sw_if.in_ready !== 1'b1 || dbg_state !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async_ctrl got valid=%b done=%b rdy=%b st=%b, required 0 0 1 0",
               sw_if.out_valid, sw_if.frame_done, sw_if.in_ready, dbg_state);
    end
    tests_run++;
    if ({sw_if.sw_pixel_1, sw_if.sw_pixel_2, sw_if.sw_pixel_3, sw_if.sw_pixel_4, sw_if.sw_pixel_5,
         sw_if.sw_pixel_6, sw_if.sw_pixel_7, sw_if.sw_pixel_8, sw_if.sw_pixel_9} !== '0) begin
      tests_failed++;
      $display("FAIL rst_async_window got p5=%0d p9=%0d, required all zero", sw_if.sw_pixel_5, sw_if.sw_pixel_9);
    end
    @(negedge clk);
    rst      = 1'b0;
    hold_low = 0;
    @(negedge clk);
    tests_run++;
    if (sw_if.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_release_ready got %b, required 1", sw_if.in_ready);
    end
    clear_mon();
    push_exp_frame(0);
    send_frame(0, 0, 16, 0);
    repeat (6) @(negedge clk);
    tests_run++;
    if (got_q.size() != 4) begin
      tests_failed++;
      $display("FAIL rst_frame_count got %0d windows, required 4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      tests_run++;
      if (got_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL rst_win%0d got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    tests_run++;
    if (fd_cnt != 1) begin
      tests_failed++;
      $display("FAIL rst_frame_done got %0d pulses, required 1", fd_cnt);
    end
  endtask

  task automatic test_gapped_input();
    int emit_idx[4] = '{10, 11, 14, 15};
    clear_mon();
    push_exp_frame(0);
    send_frame(0, 0, 16, 1);
    repeat (6) @(negedge clk);
    tests_run++;
    if (got_q.size() != 4) begin
      tests_failed++;
      $display("FAIL gap_count got %0d windows, required 4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      tests_run++;
      if (got_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL gap_win%0d got %h, required %h", k, got_q[k], exp_q[k]);
      end
      tests_run++;
      if (win_cyc_q[k] != acc_cyc[emit_idx[k]] + 1) begin
        tests_failed++;
        $display("FAIL gap_latency%0d got cycle %0d, required %0d", k, win_cyc_q[k], acc_cyc[emit_idx[k]] + 1);
      end
    end
    tests_run++;
    if (fd_cnt != 1) begin
      tests_failed++;
      $display("FAIL gap_frame_done got %0d pulses, required 1", fd_cnt);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    sw_if.in_pixel = '0;
    sw_if.in_valid = 1'b0;
    sw_if.in_sof   = 1'b0;
    clear_mon();
    test_reset();
    test_basic_stream();
    test_stall();
    test_back_to_back();
    test_sof_resync();
    test_async_reset();
    test_gapped_input();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sliding_window_gen.md
Name: sliding_window_gen

Overview:
- Producer side of the 3x3 window interface consumed by the filter.
- Accepts a raster-order pixel stream, one pixel per handshake, and buffers the two previous image rows in internal line buffers.
- Emits one full 3x3 neighbourhood (sw_pixel_1..9) for every interior pixel, with a valid/ready handshake.
- Replaces the flat-memory window fetch with a streaming front end.

Parameters:
- IMG_W, 128, pixels per line (>=3)
- IMG_H, 128, lines per frame (>=3)
- DW, 8, pixel width in bits

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- in_pixel  input  DW  incoming pixel, raster order
- in_valid  input  1  in_pixel valid
- in_sof  input  1  start of frame; qualifies in_pixel as (row 0, col 0)
- in_ready  output  1  block can accept in_pixel this cycle
- out_valid  output  1  window on sw_pixel_1..9 valid (drives filter act)
- out_ready  input  1  consumer takes window this cycle
- sw_pixel_1 .. sw_pixel_9  output  DW each  3x3 window, row-major: 1 = top-left (row r-2, col c-2), 5 = centre (r-1, c-1), 9 = bottom-right (r, c)
- frame_done  output  1  one-cycle pulse when last window of the frame is consumed

Behaviour:
- Reset (async, rst=1): row/col counters=0, out_valid=0, frame_done=0, sw_pixel_*=0, window shift registers=0, in_ready=1. Line buffer contents undefined and not reset.
- Accept: accept = in_valid && in_ready.
- in_ready = !out_valid || out_ready. Combinational; a window held by the consumer stalls input.
- Per accept at (row, col):
  - read lb1[col] (row-1) and lb0[col] (row-2);
  - shift the 3-column window left; new right column = {lb0[col], lb1[col], in_pixel};
  - write lb0[col] <= lb1[col], lb1[col] <= in_pixel.
- Window emit:
  - if row>=2 && col>=2 at accept, out_valid=1 on the next cycle with the updated window.
  - Latency: exactly 1 cycle from accept to out_valid.
- Output hold: out_valid && !out_ready -> out_valid and sw_pixel_* held stable, no accept.
- Clear: out_valid && out_ready with no new emitting accept -> out_valid=0 next cycle. Simultaneous consume and emitting accept -> out_valid stays 1 with the new window, no bubble.
- Counters:
  - col increments per accept; wraps to 0 at IMG_W-1 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 (next frame).
  - Counter widths = clog2 of the dimension.
- Line-start columns: for col<2, the window shift still occurs. Windows are emitted only for interior centres, so (IMG_W-2)*(IMG_H-2) windows per frame. No border replication.
- in_sof: an accepted pixel with in_sof=1 is treated as (0,0) regardless of the counters, then counting continues from (0,1). A pending out_valid is not cancelled. in_sof mid-frame aborts the frame without frame_done.
- frame_done: 1-cycle pulse, the cycle after the window with centre (IMG_H-2, IMG_W-2) is consumed (out_valid && out_ready).
- rst mid-frame: immediate clear as above. The next frame must begin with in_sof or at counter (0,0).
- Line buffers: IMG_W x DW each, single write + single read per cycle, same address. Read-before-write semantics required.

Test Plan:
1. IMG_W=IMG_H=4, pixels 0..15 streamed, out_ready=1 -> exactly 4 windows: {0,1,2,4,5,6,8,9,10}, {1,2,3,5,6,7,9,10,11}, {4,5,6,8,9,10,12,13,14}, {5,6,7,9,10,11,13,14,15}. out_valid rises 1 cycle after pixel 10 is accepted; frame_done pulses once after the 4th window.
2. Same stream, out_ready=0 for 5 cycles after the first window -> window 1 held stable, in_ready=0 during the stall, no pixel lost; remaining windows match scenario 1.
3. Two back-to-back frames (0..15 then 100..115) -> second frame windows use only second-frame data, e.g. first = {100,101,102,104,105,106,108,109,110}; two frame_done pulses.
4. in_sof asserted on pixel 200 after 7 pixels of a frame -> counters resync; the following 15 pixels produce windows relative to 200; no frame_done for the aborted frame.
5. rst pulsed asynchronously mid-frame with out_valid=1 -> out_valid, frame_done, sw_pixel_* = 0 immediately; in_ready=1 after release; a fresh 0..15 frame reproduces scenario 1.
6. in_valid toggling every other cycle, out_ready=1 -> same 4 windows as scenario 1, each exactly 1 cycle after its emitting accept.
